serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//   Parametrised digit-serial adder/subtractor: two's-complement A+B or A-B over WIDTH bits,
//   DIGIT bits per clock, LSB digit first, through one DIGIT-bit adder slice.
//   Start/busy/done handshake with carry, signed-overflow and zero flags, plus optional
//   signed saturation. Area-lean arithmetic unit for datapaths that can tolerate latency.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; >= 2
//   DIGIT  4   bits processed per cycle; 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0
//   (derived) NDIG = WIDTH/DIGIT digits per operation
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request; sampled only when busy==0
//   a       in   WIDTH  operand A; latched when start is accepted
//   b       in   WIDTH  operand B; latched when start is accepted
//   sub     in   1      0: A+B, 1: A-B (B inverted, carry-in 1); latched with operands
//   sat     in   1      1: clamp result on signed overflow; latched with operands
//   busy    out  1      operation in progress; start ignored while high
//   done    out  1      single-cycle pulse; result/flags valid
//   result  out  WIDTH  sum/difference (saturated if sat & ovf)
//   cout    out  1      raw carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned)
//   ovf     out  1      signed overflow (carry into MSB XOR carry out of MSB)
//   zero    out  1      result == 0, evaluated after saturation
// BEHAVIOUR
//   Reset (rst_n=0, async): state IDLE; busy, done, result, cout, ovf, zero all 0; digit counter 0.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: start=1 at edge E0 latches a, b^{WIDTH{sub}}, sub, sat; carry reg = sub; count = 0; go RUN.
//   - RUN: edges E1..E_NDIG each add digit[count] of A and B' plus carry reg, shift the DIGIT-bit
//     sum into the result register from the MSB end, update carry reg, count++.
//     At E_NDIG: final digit done; capture cout, ovf from the final slice; apply saturation; go DONE.
//   - DONE: done=1 for exactly this one cycle; next edge (E_NDIG+1) -> IDLE.
//   - busy=1 in RUN and DONE (from after E0 through E_NDIG+1). Latency start-sample to done = NDIG cycles.
//   - start while busy (including DONE cycle) is ignored; no queueing. Operand changes while busy ignored.
//   - Back-to-back: earliest next accepted start is the edge after DONE (E_NDIG+2 relative).
//   Arithmetic: modulo 2^WIDTH. ovf = c_in(MSB) ^ c_out(MSB).
//   Saturation (sat=1, ovf=1): result = 0 MSB + ones (max positive) if the true result's sign is
//   positive (i.e. raw result MSB = 1), else 1 MSB + zeros (min negative). cout/ovf report raw values.
//   Outputs result/cout/ovf/zero: updated only at E_NDIG; held stable until the next operation's
//   E_NDIG. Intermediate shifting uses an internal register, never visible on result.
//   DIGIT == WIDTH: NDIG = 1, single RUN cycle. DIGIT == 1: fully bit-serial.
//   Reset mid-operation: abort immediately, all outputs 0, no done pulse; next start after release
//   runs normally.
// TESTING  (WIDTH=16, DIGIT=4 unless noted)
//   1. a=0x1234 b=0x0FED sub=0 -> done 4 cycles after start; result 0x2221, cout 0, ovf 0, zero 0.
//   2. a=0x0005 b=0x0007 sub=1 -> result 0xFFFE, cout 0, ovf 0, zero 0.
//   3. a=0x7FFF b=0x0001 sub=0: sat=0 -> 0x8000, ovf 1, cout 0; sat=1 -> 0x7FFF, ovf 1.
//   4. a=0x8000 b=0x0001 sub=1 sat=1 -> result 0x8000, ovf 1, cout 1; a=b=0x1234 sub=1 -> 0x0000, zero 1, cout 1.
//   5. start held high continuously -> exactly one done per NDIG+2 cycles; operand change mid-RUN
//      has no effect; rst_n low in RUN cycle 2 -> busy/done/result 0 at once, no done pulse.
//   6. Sweep DIGIT in {1, 16} and WIDTH=8/DIGIT=2 with random a,b,sub,sat vs. reference model;
//      latency = NDIG cycles each configuration.

Source files
------------

// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial two's-complement adder/subtractor.
//   Computes A+B or A-B over WIDTH bits, DIGIT bits per clock, LSB digit
//   first, through a single DIGIT-bit adder slice. Optional signed saturation.
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits per cycle (WIDTH % DIGIT == 0)
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request, sampled only while idle
//   a, b, sub, sat  operands, subtract select, saturate enable (latched on start)
//   busy            high from the accept edge until the cycle after done
//   done            one-cycle pulse: result/cout/ovf/zero valid
//   result          sum/difference, saturated when sat and ovf
//   cout            raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf             signed overflow of the raw result
//   zero            result == 0, after saturation
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;      // already inverted for subtract
    logic [WIDTH-1:0] shift_r;  // partial result, filled from the MSB end
    logic             sat_r;
    logic             carry_r;
    logic [CW-1:0]    count_r;

    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT:0]   slice_s;
    logic [DIGIT-1:0] sum_s;
    logic             c_out_s;
    logic             c_msb_in_s;
    logic             ovf_s;
    logic             last_s;
    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;
    logic [WIDTH-1:0] shift_next_s;
    logic [WIDTH-1:0] final_s;

    // Single adder slice on the current low digit, plus next-state shifts.
    always_comb begin
        a_dig_s      = a_r[DIGIT-1:0];
        b_dig_s      = b_r[DIGIT-1:0];
        slice_s      = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_r};
        sum_s        = slice_s[DIGIT-1:0];
        c_out_s      = slice_s[DIGIT];
        // Carry into the top bit of the slice recovered from its sum bit;
        // only meaningful on the final digit, where it is the carry into the MSB.
        c_msb_in_s   = sum_s[DIGIT-1] ^ a_dig_s[DIGIT-1] ^ b_dig_s[DIGIT-1];
        ovf_s        = c_msb_in_s ^ c_out_s;
        last_s       = (count_r == CW'(NDIG - 1));
        a_next_s     = a_r >> DIGIT;
        b_next_s     = b_r >> DIGIT;
        shift_next_s = (shift_r >> DIGIT) | (WIDTH'(sum_s) << (WIDTH - DIGIT));
    end

    // Saturation: raw MSB set on overflow means the true result was positive.
    always_comb begin
        if (sat_r && ovf_s) begin
            if (shift_next_s[WIDTH-1]) begin
                final_s = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                final_s = {1'b1, {(WIDTH-1){1'b0}}};
            end
        end else begin
            final_s = shift_next_s;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            shift_r <= {WIDTH{1'b0}};
            sat_r   <= 1'b0;
            carry_r <= 1'b0;
            count_r <= {CW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= {WIDTH{1'b0}};
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b ^ {WIDTH{sub}};
                        sat_r   <= sat;
                        carry_r <= sub;
                        count_r <= {CW{1'b0}};
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    a_r     <= a_next_s;
                    b_r     <= b_next_s;
                    shift_r <= shift_next_s;
                    carry_r <= c_out_s;
                    count_r <= count_r + CW'(1);
                    if (last_s) begin
                        result  <= final_s;
                        cout    <= c_out_s;
                        ovf     <= ovf_s;
                        zero    <= (final_s == {WIDTH{1'b0}});
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: self-checking bench for serial_add_sub.
//   Four instances (16/4, 16/1, 16/16, 8/2) share clock and reset; directed
//   cases, a held-start run, a mid-operation reset and random operations
//   compared against an arithmetic reference model.
module tb_serial_add_sub;

    logic        clk;
    logic        rst_n;
    logic        start_v [4];
    logic [15:0] a_v     [4];
    logic [15:0] b_v     [4];
    logic        sub_v   [4];
    logic        sat_v   [4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic [15:0] res_v   [4];
    logic        cout_v  [4];
    logic        ovf_v   [4];
    logic        zero_v  [4];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int w_of(input int k);
        case (k)
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int d_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            2:       return 16;
            default: return 2;
        endcase
    endfunction

    function automatic int ndig_of(input int k);
        return w_of(k) / d_of(k);
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = w_of(g);
        logic         busy_l;
        logic         done_l;
        logic [W-1:0] res_l;
        logic         cout_l;
        logic         ovf_l;
        logic         zero_l;

        serial_add_sub #(.WIDTH(W), .DIGIT(d_of(g))) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start_v[g]),
            .a      (a_v[g][W-1:0]),
            .b      (b_v[g][W-1:0]),
            .sub    (sub_v[g]),
            .sat    (sat_v[g]),
            .busy   (busy_l),
            .done   (done_l),
            .result (res_l),
            .cout   (cout_l),
            .ovf    (ovf_l),
            .zero   (zero_l)
        );

        assign busy_v[g] = busy_l;
        assign done_v[g] = done_l;
        assign res_v[g]  = 16'(res_l);
        assign cout_v[g] = cout_l;
        assign ovf_v[g]  = ovf_l;
        assign zero_v[g] = zero_l;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on signed/unsigned interpretations.
    task automatic ref_op(input int w, input logic [15:0] a_in, input logic [15:0] b_in,
                          input logic sub_in, input logic sat_in,
                          output logic [15:0] r, output logic co, output logic ov, output logic z);
        longint mask, half, ua, ub, raw, sa, sb, t, rr;
        mask = (64'sd1 <<< w) - 64'sd1;
        half = 64'sd1 <<< (w - 1);
        ua   = longint'(a_in) & mask;
        ub   = longint'(b_in) & mask;
        raw  = sub_in ? (ua + ((~ub) & mask) + 64'sd1) : (ua + ub);
        co   = ((raw >>> w) & 64'sd1) != 64'sd0;
        sa   = (ua >= half) ? (ua - (mask + 64'sd1)) : ua;
        sb   = (ub >= half) ? (ub - (mask + 64'sd1)) : ub;
        t    = sub_in ? (sa - sb) : (sa + sb);
        ov   = (t >= half) || (t < -half);
        rr   = raw & mask;
        if (sat_in && ov) rr = (t > 64'sd0) ? (half - 64'sd1) : half;
        r    = 16'(rr);
        z    = (rr == 64'sd0);
    endtask

    task automatic run_op(input int k, input logic [15:0] a_in, input logic [15:0] b_in,
                          input logic sub_in, input logic sat_in,
                          output logic [15:0] r, output logic co, output logic ov, output logic z);
        int          cyc;
        logic [15:0] prev;
        @(negedge clk);
        prev       = res_v[k];
        a_v[k]     = a_in;
        b_v[k]     = b_in;
        sub_v[k]   = sub_in;
        sat_v[k]   = sat_in;
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        check_value($sformatf("op%0d.busy_after_start", k), 32'(busy_v[k]), 32'd1);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (!done_v[k]) check_value($sformatf("op%0d.result_hold", k), 32'(res_v[k]), 32'(prev));
        end while (!done_v[k] && cyc < 40);
        check_value($sformatf("op%0d.latency", k), 32'(cyc), 32'(ndig_of(k)));
        check_value($sformatf("op%0d.busy_in_done", k), 32'(busy_v[k]), 32'd1);
        r  = res_v[k];
        co = cout_v[k];
        ov = ovf_v[k];
        z  = zero_v[k];
        @(posedge clk);
        #1;
        check_value($sformatf("op%0d.done_single", k), 32'(done_v[k]), 32'd0);
        check_value($sformatf("op%0d.busy_cleared", k), 32'(busy_v[k]), 32'd0);
    endtask

    task automatic directed(input string tag, input logic [15:0] a_in, input logic [15:0] b_in,
                            input logic sub_in, input logic sat_in, input logic [15:0] er,
                            input logic eco, input logic eov, input logic ez);
        logic [15:0] r;
        logic        co, ov, z;
        run_op(0, a_in, b_in, sub_in, sat_in, r, co, ov, z);
        check_value({tag, ".result"}, 32'(r), 32'(er));
        check_value({tag, ".cout"}, 32'(co), 32'(eco));
        check_value({tag, ".ovf"}, 32'(ov), 32'(eov));
        check_value({tag, ".zero"}, 32'(z), 32'(ez));
    endtask

    initial begin
        logic [15:0] r, er, first_res;
        logic        co, ov, z, eco, eov, ez;
        int          pulses, first_cyc;

        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start_v[k] = 1'b0;
            a_v[k]     = 16'h0000;
            b_v[k]     = 16'h0000;
            sub_v[k]   = 1'b0;
            sat_v[k]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check_value($sformatf("reset%0d.busy", k), 32'(busy_v[k]), 32'd0);
            check_value($sformatf("reset%0d.done", k), 32'(done_v[k]), 32'd0);
            check_value($sformatf("reset%0d.result", k), 32'(res_v[k]), 32'd0);
            check_value($sformatf("reset%0d.flags", k),
                        32'({cout_v[k], ovf_v[k], zero_v[k]}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        directed("add_basic", 16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0);
        directed("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("add_sat",   16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        directed("sub_sat",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
        directed("sub_zero",  16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // start held high: one done every NDIG+2 cycles, operand change mid-RUN ignored
        @(negedge clk);
        a_v[0]     = 16'h1234;
        b_v[0]     = 16'h0FED;
        sub_v[0]   = 1'b0;
        sat_v[0]   = 1'b0;
        start_v[0] = 1'b1;
        pulses     = 0;
        first_cyc  = 0;
        first_res  = 16'h0000;
        @(posedge clk);
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                pulses++;
                if (pulses == 1) begin
                    first_cyc = i;
                    first_res = res_v[0];
                end
            end
            if (i == 2) a_v[0] = 16'hFFFF;
        end
        start_v[0] = 1'b0;
        check_value("held.pulses", 32'(pulses), 32'd3);
        check_value("held.first_latency", 32'(first_cyc), 32'd4);
        check_value("held.first_result", 32'(first_res), 32'h2221);
        repeat (3) @(posedge clk);

        // reset during RUN cycle 2: immediate clear, no done pulse
        @(negedge clk);
        a_v[0]     = 16'h1111;
        b_v[0]     = 16'h2222;
        sub_v[0]   = 1'b0;
        sat_v[0]   = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("midrst.busy", 32'(busy_v[0]), 32'd0);
        check_value("midrst.done", 32'(done_v[0]), 32'd0);
        check_value("midrst.result", 32'(res_v[0]), 32'd0);
        check_value("midrst.flags", 32'({cout_v[0], ovf_v[0], zero_v[0]}), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) pulses++;
        end
        check_value("midrst.no_done", 32'(pulses), 32'd0);
        directed("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);

        // random operations on every configuration against the reference model
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 40; n++) begin
                logic [15:0] ra, rb;
                logic        rs, rt;
                ra = 16'($urandom);
                rb = 16'($urandom);
                rs = 1'($urandom);
                rt = 1'($urandom);
                if (n < 4) begin
                    // corner operands: extremes of the signed range
                    ra = (n[0]) ? (16'hFFFF >> (16 - w_of(k) + 1)) : (16'h0001 << (w_of(k) - 1));
                    rb = 16'h0001;
                end
                ref_op(w_of(k), ra, rb, rs, rt, er, eco, eov, ez);
                run_op(k, ra, rb, rs, rt, r, co, ov, z);
                check_value($sformatf("rand%0d.%0d.result", k, n), 32'(r), 32'(er));
                check_value($sformatf("rand%0d.%0d.cout", k, n), 32'(co), 32'(eco));
                check_value($sformatf("rand%0d.%0d.ovf", k, n), 32'(ov), 32'(eov));
                check_value($sformatf("rand%0d.%0d.zero", k, n), 32'(z), 32'(ez));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
